div_iter: RTL and testbench

Iterative 32-cycle radix-2 divider owned by the EX stage, serving DIV/DIVU. EX launches an operation, holds the pipeline through its stall request, and captures quotient/remainder on `done` into the hilo portion of the EX-to-MEM bus (LO = quotient, HI = remainder). From there the result travels through MEM to WB unchanged. Flushes from the CP0 exception path cancel an in-flight operation.

---
 rtl/div_iter_pkg.sv | 20 ++
 rtl/div_step.sv | 22 ++
 rtl/div_iter.sv | 138 +++++++++++++
 tb/tb_div_iter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
// Imported by div_iter and div_step.
package div_iter_pkg;

    localparam int DivWidth = 32;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivBusy = 2'd1,
        DivDone = 2'd2
    } div_state_e;

    // Divide-by-zero: quotient is all ones, remainder is the raw dividend.
    localparam logic DivZeroQuotBit = 1'b1;

    function automatic int div_cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract and compare.
// Purely combinational; instantiated once by div_iter.
module div_step
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DivWidth
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] trial;

    always_comb begin
        trial   = {1'b0, rem_in} - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        rem_out = q_bit ? trial[WIDTH:0] : rem_in;
    end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Results land in LO (quotient) and HI (remainder) on the done pulse.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = DivWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stallreq,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = div_cnt_bits(WIDTH);
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] acc_nxt;
    logic [WIDTH-1:0] dvsr;
    logic             q_neg;
    logic             r_neg;

    logic             launch;
    logic             div_zero;
    logic             last;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   rem_in;
    logic [WIDTH:0]   rem_out;
    logic             q_bit;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic             unused_acc_msb;

    assign launch   = (state == DivIdle) & start & ~flush;
    assign div_zero = (divisor == '0);
    assign last     = (state == DivBusy) & (cnt == LastCnt);

    assign stallreq = launch | (state == DivBusy);
    assign done     = (state == DivDone);

    // Partial remainder stays below the divisor, so its top bit is always 0.
    assign unused_acc_msb = acc[2*WIDTH];

    always_comb begin
        dvd_mag = (signed_div & dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
        dvs_mag = (signed_div & divisor[WIDTH-1]) ? ('0 - divisor) : divisor;
    end

    assign rem_in = acc[2*WIDTH-1:WIDTH-1];

    div_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .rem_in  (rem_in),
        .divisor (dvsr),
        .rem_out (rem_out),
        .q_bit   (q_bit)
    );

    always_comb begin
        acc_nxt = {rem_out, acc[WIDTH-2:0], q_bit};
        q_fin   = q_neg ? ('0 - acc_nxt[WIDTH-1:0]) : acc_nxt[WIDTH-1:0];
        r_fin   = r_neg ? ('0 - acc_nxt[2*WIDTH-1:WIDTH])
                        : acc_nxt[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DivIdle;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DivIdle: begin
                if (launch) begin
                    state_nxt = div_zero ? DivDone : DivBusy;
                end
            end
            DivBusy: begin
                if (cnt == LastCnt) begin
                    state_nxt = DivDone;
                end
            end
            DivDone: state_nxt = DivIdle;
            default: state_nxt = DivIdle;
        endcase
        if (flush) begin
            state_nxt = DivIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            dvsr      <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (launch) begin
            cnt   <= '0;
            acc   <= {{(WIDTH+1){1'b0}}, dvd_mag};
            dvsr  <= dvs_mag;
            q_neg <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg <= signed_div & dividend[WIDTH-1];
            if (div_zero) begin
                quotient  <= {WIDTH{DivZeroQuotBit}};
                remainder <= dividend;
            end
        end else if (state == DivBusy) begin
            acc <= acc_nxt;
            cnt <= cnt + CW'(1);
            if (last) begin
                quotient  <= q_fin;
                remainder <= r_fin;
            end
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed cases plus randomized
// operands checked against a plain-arithmetic reference model.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stallreq;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_iter #(
        .WIDTH      (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .stallreq   (stallreq),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit s, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Called just after a falling edge with the divider idle.
    task automatic run_div(input string tag, input bit s,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eq, input logic [31:0] er,
                           input bit replay);
        int   lat;
        int   done_at;
        int   stall_hi;
        logic stall_in_done;
        lat           = (b == 32'd0) ? 1 : 33;
        done_at       = 0;
        stall_hi      = 0;
        stall_in_done = 1'b0;
        signed_div    = s;
        dividend      = a;
        divisor       = b;
        start         = 1'b1;
        #1;
        chk({tag, "_stall_T"}, 32'(stallreq), 32'd1);
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            @(negedge clk);
            start = replay && (i % 4 == 0) && (i < lat);
            #1;
            if (done) begin
                done_at       = i;
                stall_in_done = stallreq;
            end else if (stallreq) begin
                stall_hi++;
            end
        end
        start = 1'b0;
        chk({tag, "_done_at"}, 32'(done_at), 32'(lat));
        chk({tag, "_stall_cyc"}, 32'(stall_hi), 32'(lat - 1));
        chk({tag, "_stall_done"}, 32'(stall_in_done), 32'd0);
        chk({tag, "_quot"}, quotient, eq);
        chk({tag, "_rem"}, remainder, er);
        @(negedge clk);
        #1;
        chk({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] a;
        logic [31:0] b;
        bit          s;

        rst        = 1'b1;
        flush      = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_quot", quotient, 32'd0);
        chk("rst_rem", remainder, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(stallreq), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        run_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2,
                32'h7FFF_FFFC, 32'd1, 1'b0);
        run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                32'h8000_0000, 32'd0, 1'b0);
        run_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1,
                32'hFFFF_FFFF, 32'd0, 1'b0);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
                32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div("s_dz_neg", 1'b1, 32'hFFFF_FF00, 32'd0,
                32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b0);
        run_div("u_dz", 1'b0, 32'h1234, 32'd0,
                32'hFFFF_FFFF, 32'h1234, 1'b0);

        // Flush at T+10 cancels; outputs keep the divide-by-zero result.
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_stall_T10", 32'(stallreq), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_stall_T11", 32'(stallreq), 32'd0);
        chk("fl_done_T11", 32'(done), 32'd0);
        chk("fl_quot_keep", quotient, 32'hFFFF_FFFF);
        chk("fl_rem_keep", remainder, 32'h1234);
        @(negedge clk);
        #1;
        run_div("fl_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset at T+5 during BUSY clears outputs and returns to idle.
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_quot", quotient, 32'd0);
        chk("mr_rem", remainder, 32'd0);
        chk("mr_stall", 32'(stallreq), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        @(negedge clk);
        #1;

        run_div("replay", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b1);

        for (int n = 0; n < 30; n++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFF_FFFF;
                3:       b = a >> $urandom_range(1, 31);
                default: b = $urandom;
            endcase
            if (n % 10 == 0) a = 32'h8000_0000;
            model(s, a, b, eq, er);
            run_div($sformatf("rnd%0d", n), s, a, b, eq, er, (n % 3 == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
